// File: rtl/gcd_host_driver.sv
// Host-side initiator that sequences an operand pair into the GCD processor
// through its Input/Enter/Halt/Output protocol and returns the result or a timeout.
module gcd_host_driver #(
  parameter int WIDTH          = 8,
  parameter int RESET_CYCLES   = 1,
  parameter int SETTLE_CYCLES  = 10,
  parameter int ENTER_CYCLES   = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic [WIDTH-1:0] ReqA,
  input  logic [WIDTH-1:0] ReqB,
  output logic             ProcReset,
  output logic [WIDTH-1:0] ProcInput,
  output logic             ProcEnter,
  input  logic             ProcHalt,
  input  logic [WIDTH-1:0] ProcOutput,
  output logic             RspValid,
  input  logic             RspReady,
  output logic [WIDTH-1:0] RspResult,
  output logic             RspTimeout,
  output logic             Busy
);

  localparam int MAX_RS  = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int MAX_ET  = (ENTER_CYCLES > TIMEOUT_CYCLES) ? ENTER_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_MAX = (MAX_RS > MAX_ET) ? MAX_RS : MAX_ET;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RESET_LAST   = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] ENTER_LAST   = CW'(ENTER_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, PRST, SET_A, ENT_A, SET_B, ENT_B, WAIT_HALT, RESP
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  opA_q, opA_d;
  logic [WIDTH-1:0]  opB_q, opB_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              timeout_q, timeout_d;
  logic              rstSeen_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      opA_q     <= '0;
      opB_q     <= '0;
      result_q  <= '0;
      timeout_q <= 1'b0;
      rstSeen_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opA_q     <= opA_d;
      opB_q     <= opB_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
      rstSeen_q <= 1'b0;
    end
  end

  // Every transition clears the counter so each state starts timing from zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    opA_d     = opA_q;
    opB_d     = opB_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (ReqValid) begin
          opA_d = ReqA;
          opB_d = ReqB;
          if (ReqA == '0 || ReqB == '0) begin
            result_d  = ReqA | ReqB;
            timeout_d = 1'b0;
            state_d   = RESP;
          end else begin
            state_d = PRST;
          end
        end
      end
      PRST: begin
        if (cnt_q == RESET_LAST) begin
          state_d = SET_A;
          cnt_d   = '0;
        end
      end
      SET_A: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ENT_A;
          cnt_d   = '0;
        end
      end
      ENT_A: begin
        if (cnt_q == ENTER_LAST) begin
          state_d = SET_B;
          cnt_d   = '0;
        end
      end
      SET_B: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ENT_B;
          cnt_d   = '0;
        end
      end
      ENT_B: begin
        if (cnt_q == ENTER_LAST) begin
          state_d = WAIT_HALT;
          cnt_d   = '0;
        end
      end
      WAIT_HALT: begin
        // Halt is checked first so it wins over a coincident timeout.
        if (ProcHalt) begin
          result_d  = ProcOutput;
          timeout_d = 1'b0;
          state_d   = RESP;
          cnt_d     = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          result_d  = '0;
          timeout_d = 1'b1;
          state_d   = RESP;
          cnt_d     = '0;
        end
      end
      RESP: begin
        cnt_d = '0;
        if (RspReady) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    ProcInput = '0;
    unique case (state_q)
      SET_A, ENT_A:           ProcInput = opA_q;
      SET_B, ENT_B, WAIT_HALT: ProcInput = opB_q;
      default:                ProcInput = '0;
    endcase
  end

  // rstSeen_q keeps the processor in reset for the cycle following a system reset.
  assign ProcReset  = rstSeen_q | (state_q == PRST);
  assign ProcEnter  = (state_q == ENT_A) || (state_q == ENT_B);
  assign ReqReady   = (state_q == IDLE);
  assign Busy       = (state_q != IDLE);
  assign RspValid   = (state_q == RESP);
  assign RspResult  = result_q;
  assign RspTimeout = timeout_q;

endmodule

// File: tb/tb_gcd_host_driver.sv
// Self-checking bench for gcd_host_driver: a behavioural GCD processor stand-in,
// directed protocol/timing scenarios and randomized operand pairs.
module tb_gcd_host_driver;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       ReqValid;
  logic       ReqReady;
  logic [7:0] ReqA;
  logic [7:0] ReqB;
  logic       ProcReset;
  logic [7:0] ProcInput;
  logic       ProcEnter;
  logic       ProcHalt;
  logic [7:0] ProcOutput;
  logic       RspValid;
  logic       RspReady;
  logic [7:0] RspResult;
  logic       RspTimeout;
  logic       Busy;

  gcd_host_driver #(
    .WIDTH(8), .RESET_CYCLES(1), .SETTLE_CYCLES(10), .ENTER_CYCLES(1), .TIMEOUT_CYCLES(1024)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqA(ReqA), .ReqB(ReqB),
    .ProcReset(ProcReset), .ProcInput(ProcInput), .ProcEnter(ProcEnter),
    .ProcHalt(ProcHalt), .ProcOutput(ProcOutput),
    .RspValid(RspValid), .RspReady(RspReady), .RspResult(RspResult),
    .RspTimeout(RspTimeout), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  int checkCount = 0;
  int passCount  = 0;
  int complementErrors = 0;

  // Per-transaction observations, cycle 0 being the accept edge.
  int         rspCycle;
  int         procResetCycles;
  int         enterCycles[$];
  logic [7:0] enterInputs[$];

  bit haltEnable = 1'b1;

  function automatic int gcdRef(input int a, input int b);
    int x = a;
    int y = b;
    while (y != 0) begin
      int t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  // Processor stand-in: latches A then B on Enter rising edges, computes by repeated
  // subtraction after a random delay, and keeps Halt high until it is reset again.
  initial begin : procModel
    logic [7:0] mA, mB;
    int stage = 0;
    int lat = 0;
    bit enterPrev = 1'b0;
    bit clearPending = 1'b0;
    ProcHalt = 1'b0;
    ProcOutput = 8'd0;
    mA = 8'd0;
    mB = 8'd0;
    forever begin
      @(negedge Clock);
      if (ProcReset === 1'b1) begin
        stage = 0;
        enterPrev = 1'b0;
        clearPending = 1'b1;
      end else begin
        if (clearPending) begin
          ProcHalt = 1'b0;
          ProcOutput = 8'd0;
          clearPending = 1'b0;
        end
        if (ProcEnter === 1'b1 && !enterPrev) begin
          if (stage == 0) begin
            mA = ProcInput;
            stage = 1;
          end else if (stage == 1) begin
            mB = ProcInput;
            stage = 2;
            lat = $urandom_range(15, 2);
          end
        end
        enterPrev = (ProcEnter === 1'b1);
        if (stage == 2) begin
          if (lat == 0) begin
            if (haltEnable) begin
              while (mA != mB && mA != 0 && mB != 0) begin
                if (mA > mB) mA = mA - mB;
                else mB = mB - mA;
              end
              ProcOutput = mA;
              ProcHalt = 1'b1;
            end
            stage = 3;
          end else begin
            lat--;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog observed=expired expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Presents one request and follows it until RspValid or the cycle bound.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input int bound);
    int cyc;
    checkOutput("req_ready_idle", ReqReady, 1);
    ReqA = a;
    ReqB = b;
    ReqValid = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    ReqValid = 1'b0;
    rspCycle = -1;
    procResetCycles = 0;
    enterCycles.delete();
    enterInputs.delete();
    cyc = 1;
    while (cyc <= bound) begin
      if (Busy === ReqReady) complementErrors++;
      if (ProcEnter === 1'b1) begin
        enterCycles.push_back(cyc);
        enterInputs.push_back(ProcInput);
      end
      if (ProcReset === 1'b1) procResetCycles++;
      if (RspValid === 1'b1) begin
        rspCycle = cyc;
        break;
      end
      @(negedge Clock);
      cyc++;
    end
    checkOutput("rsp_valid_arrives", RspValid, 1);
  endtask

  // Holds the response for holdCycles (optionally offering a new request), then accepts it.
  task automatic respond(input int holdCycles, input bit sneak);
    logic [7:0] heldRes;
    logic       heldTo;
    int holdErrors = 0;
    if (rspCycle < 0) return;
    heldRes = RspResult;
    heldTo = RspTimeout;
    for (int i = 0; i < holdCycles; i++) begin
      if (sneak) begin
        ReqValid = 1'b1;
        ReqA = 8'd3;
        ReqB = 8'd4;
      end
      @(negedge Clock);
      if (RspValid !== 1'b1 || RspResult !== heldRes || RspTimeout !== heldTo || ReqReady !== 1'b0)
        holdErrors++;
    end
    if (holdCycles > 0) checkOutput("rsp_hold_stable", holdErrors, 0);
    ReqValid = 1'b0;
    RspReady = 1'b1;
    @(negedge Clock);
    RspReady = 1'b0;
    checkOutput("rsp_valid_drop", RspValid, 0);
    checkOutput("req_ready_after", ReqReady, 1);
  endtask

  initial begin : stimulus
    Reset = 1'b1;
    ReqValid = 1'b0;
    ReqA = 8'd0;
    ReqB = 8'd0;
    RspReady = 1'b0;
    repeat (3) @(negedge Clock);

    // Values held while Reset is asserted.
    checkOutput("rst_proc_reset", ProcReset, 1);
    checkOutput("rst_proc_input", ProcInput, 0);
    checkOutput("rst_proc_enter", ProcEnter, 0);
    checkOutput("rst_rsp_valid", RspValid, 0);
    checkOutput("rst_rsp_result", RspResult, 0);
    checkOutput("rst_rsp_timeout", RspTimeout, 0);
    checkOutput("rst_busy", Busy, 0);
    Reset = 1'b0;
    @(negedge Clock);
    checkOutput("post_rst_req_ready", ReqReady, 1);
    checkOutput("post_rst_proc_reset", ProcReset, 0);

    // Directed 12/18 with exact Enter timing.
    applyStimulus(8'd12, 8'd18, 300);
    checkOutput("d1218_preset_cycles", procResetCycles, 1);
    checkOutput("d1218_enter_count", enterCycles.size(), 2);
    if (enterCycles.size() == 2) begin
      checkOutput("d1218_enter0_cycle", enterCycles[0], 12);
      checkOutput("d1218_enter1_cycle", enterCycles[1], 23);
      checkOutput("d1218_enter0_input", enterInputs[0], 12);
      checkOutput("d1218_enter1_input", enterInputs[1], 18);
    end
    checkOutput("d1218_result", RspResult, gcdRef(12, 18));
    checkOutput("d1218_timeout", RspTimeout, 0);
    respond(0, 1'b0);

    // Zero operands bypass the processor.
    applyStimulus(8'd0, 8'd9, 5);
    checkOutput("z09_latency", rspCycle, 1);
    checkOutput("z09_preset_cycles", procResetCycles, 0);
    checkOutput("z09_enter_count", enterCycles.size(), 0);
    checkOutput("z09_result", RspResult, 9);
    checkOutput("z09_timeout", RspTimeout, 0);
    respond(0, 1'b0);
    applyStimulus(8'd0, 8'd0, 5);
    checkOutput("z00_latency", rspCycle, 1);
    checkOutput("z00_result", RspResult, 0);
    respond(0, 1'b0);

    // Backpressured response with a competing request.
    applyStimulus(8'd21, 8'd14, 300);
    checkOutput("bp_result", RspResult, gcdRef(21, 14));
    respond(5, 1'b1);
    checkOutput("bp_no_accept_busy", Busy, 0);

    // Random operand pairs.
    for (int n = 0; n < 100; n++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(128, 1));
      rb = 8'($urandom_range(128, 1));
      applyStimulus(ra, rb, 300);
      checkOutput($sformatf("rand%0d_result_%0d_%0d", n, ra, rb), RspResult, gcdRef(int'(ra), int'(rb)));
      checkOutput($sformatf("rand%0d_timeout", n), RspTimeout, 0);
      respond(0, 1'b0);
    end

    // Processor never halts; previous Halt is still high during PRST.
    haltEnable = 1'b0;
    applyStimulus(8'd5, 8'd7, 1200);
    checkOutput("to_latency", rspCycle, 24 + 1024);
    checkOutput("to_flag", RspTimeout, 1);
    checkOutput("to_result", RspResult, 0);
    respond(0, 1'b0);
    haltEnable = 1'b1;

    // Reset in the middle of SET_B drops the transaction.
    checkOutput("mid_req_ready", ReqReady, 1);
    ReqA = 8'd20;
    ReqB = 8'd30;
    ReqValid = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    ReqValid = 1'b0;
    repeat (14) @(negedge Clock);
    checkOutput("mid_in_set_b_input", ProcInput, 30);
    Reset = 1'b1;
    @(negedge Clock);
    checkOutput("mid_rst_busy", Busy, 0);
    checkOutput("mid_rst_enter", ProcEnter, 0);
    checkOutput("mid_rst_proc_reset", ProcReset, 1);
    checkOutput("mid_rst_rsp_valid", RspValid, 0);
    Reset = 1'b0;
    @(negedge Clock);
    checkOutput("mid_post_proc_reset", ProcReset, 0);
    checkOutput("mid_post_rsp_valid", RspValid, 0);
    applyStimulus(8'd9, 8'd6, 300);
    checkOutput("mid_next_result", RspResult, 3);
    respond(0, 1'b0);

    checkOutput("busy_ready_complement", complementErrors, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/gcd_host_driver.md
Name: gcd_host_driver

Overview:
Synthesizable host-side initiator for the enhanced processor's operand-entry protocol (Input/Enter/Halt/Output). It accepts an operand pair over a valid/ready request port and pulses the processor's reset. It then presents operand A and pulses Enter, presents operand B and pulses Enter, and waits for Halt. It returns the captured Output, or a timeout flag, on a valid/ready response port. It replaces the manual switch/button entry path when the processor is embedded in a larger system.

Parameters:
WIDTH, 8, operand/result width
RESET_CYCLES, 1, cycles ProcReset is held high per transaction (>=1)
SETTLE_CYCLES, 10, cycles ProcInput is stable before each Enter pulse (>=1)
ENTER_CYCLES, 1, width of each ProcEnter pulse in cycles (>=1)
TIMEOUT_CYCLES, 1024, maximum cycles spent waiting for ProcHalt

Ports:
Clock  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high
ReqValid  in  1  operand pair valid
ReqReady  out  1  driver can accept a request
ReqA  in  WIDTH  first operand
ReqB  in  WIDTH  second operand
ProcReset  out  1  reset to processor
ProcInput  out  WIDTH  processor data input
ProcEnter  out  1  processor Enter strobe
ProcHalt  in  1  processor done
ProcOutput  in  WIDTH  processor result
RspValid  out  1  response valid
RspReady  in  1  consumer accepts response
RspResult  out  WIDTH  captured result
RspTimeout  out  1  1 = processor never halted; RspResult = 0
Busy  out  1  high in any state except IDLE

Behaviour:
- All outputs are registered or decoded from registered state. No combinational path runs from the Req/Rsp inputs to outputs.
- Reset values: state IDLE, ProcReset=1, ProcInput=0, ProcEnter=0, RspValid=0, RspResult=0, RspTimeout=0, Busy=0. ReqReady reads 1 from the first cycle after Reset drops. ProcReset drops the cycle after Reset deasserts.
- IDLE: ReqReady=1. When ReqValid and ReqReady are both high at an edge, latch ReqA and ReqB.
  - Either operand is 0: go to RESP with RspResult = ReqA|ReqB (gcd(0,x)=x, gcd(0,0)=0) and RspTimeout=0. RspValid rises 1 cycle after accept. The processor is not touched.
  - Otherwise go to PRST.
- PRST: ProcReset=1 for RESET_CYCLES cycles, ProcInput=0, ProcEnter=0. Then go to SET_A.
- SET_A: ProcReset=0, ProcInput=A for SETTLE_CYCLES cycles. Then go to ENT_A.
- ENT_A: ProcEnter=1 and ProcInput=A held for ENTER_CYCLES cycles. Then go to SET_B.
- SET_B: ProcEnter=0, ProcInput=B for SETTLE_CYCLES cycles. Then go to ENT_B.
- ENT_B: ProcEnter=1 and ProcInput=B held for ENTER_CYCLES cycles. Then go to WAIT_HALT.
- WAIT_HALT: ProcEnter=0, ProcInput=B held, a timeout counter runs.
  - ProcHalt sampled 1: capture ProcOutput into RspResult, RspTimeout=0, go to RESP.
  - Counter reaches TIMEOUT_CYCLES with no Halt: RspResult=0, RspTimeout=1, go to RESP.
  - If Halt and timeout coincide on the same edge, Halt wins.
- RESP: RspValid=1. RspResult and RspTimeout stay stable until RspValid and RspReady are both high at an edge. Then RspValid drops next cycle and the state returns to IDLE. ReqReady=0 throughout.
- ProcHalt is ignored in every state except WAIT_HALT, including a stale Halt from the previous transaction during PRST/SET_A.
- Timing with default parameters, cycle 0 = accept edge:
  - ProcReset high cycle 1.
  - ProcInput=A cycles 2-12.
  - ProcEnter high cycle 12.
  - ProcInput=B cycles 13-23.
  - ProcEnter high cycle 23.
  - Halt sampling from cycle 24.
- Counters are sized to hold max(RESET_CYCLES, SETTLE_CYCLES, ENTER_CYCLES, TIMEOUT_CYCLES). All counters clear on every state entry.
- Reset in any state returns to IDLE on the next edge with reset values, including ProcReset=1. The in-flight transaction is dropped and no response is produced.

Test Plan:
- ReqA=12, ReqB=18, processor computes gcd -> exactly two ProcEnter pulses, each 1 cycle wide, at cycles 12 and 23 after accept. ProcInput=12 at the first pulse and 18 at the second. RspResult=6, RspTimeout=0.
- 100 random pairs in 1..128, each checked against a software gcd -> RspResult matches every time. Busy and ReqReady are complementary throughout.
- ProcHalt tied 0, ReqA=5, ReqB=7, TIMEOUT_CYCLES=1024 -> RspValid rises exactly 1024 cycles after entering WAIT_HALT, with RspTimeout=1 and RspResult=0.
- ReqA=0, ReqB=9 -> RspResult=9 one cycle after accept. ProcReset and ProcEnter stay 0. ReqA=0, ReqB=0 -> RspResult=0.
- Run ReqA=21, ReqB=14 and hold RspReady=0 for 5 cycles -> RspValid is held and RspResult=7 stays stable. ReqReady=0 until the handshake. A new ReqValid asserted meanwhile is not accepted.
- Reset pulsed during SET_B -> next cycle: state IDLE, ProcEnter=0, ProcReset=1, no RspValid. A following request with ReqA=9, ReqB=6 completes with RspResult=3.
